divider32_seq: RTL

//  Multi-cycle iterative 32-bit integer divider for the single-cycle CPU datapath;
//  the subtractive counterpart of the combinational branch adder.

---
 rtl/divider32_seq.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/divider32_seq.sv
// Multi-cycle restoring shift-subtract divider with a start/busy/done handshake.
// Optional feature macro: SIGNED_DIV_EN adds signed_in and two's-complement division.
module divider32_seq #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] dividend_in,
    input  logic [WIDTH-1:0] divisor_in,
`ifdef SIGNED_DIV_EN
    input  logic             signed_in,
`endif
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] quotient_out,
    output logic [WIDTH-1:0] remainder_out,
    output logic             div_by_zero_out,
    output logic [1:0]       dbg_state_out
);

    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Handshake: start_in is accepted on any rising edge where the FSM is in
    // IDLE or DONE; busy_out marks iteration cycles, done_out is a one-cycle
    // pulse in which the registered results first become valid.
    state_t r_state;
    state_t w_next;

    logic [WIDTH:0]   r_part;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic [CW-1:0]    r_cnt;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic             r_dbz;

    logic             w_accept;
    logic             w_div_zero;
    logic             w_last;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [WIDTH:0]   w_part;
    logic [WIDTH-1:0] w_quo;
    logic [WIDTH-1:0] w_q_fin;
    logic [WIDTH-1:0] w_r_fin;

    assign w_accept   = start_in && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_div_zero = (divisor_in == '0);
    assign w_last     = (r_cnt == LAST);

`ifdef SIGNED_DIV_EN
    assign w_a_neg = signed_in & dividend_in[WIDTH-1];
    assign w_b_neg = signed_in & divisor_in[WIDTH-1];
`else
    assign w_a_neg = 1'b0;
    assign w_b_neg = 1'b0;
`endif

    // The most negative value maps onto itself, which is its correct unsigned magnitude.
    assign w_mag_a = w_a_neg ? (~dividend_in + 1'b1) : dividend_in;
    assign w_mag_b = w_b_neg ? (~divisor_in + 1'b1) : divisor_in;

    // State register
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start_in) begin
                    w_next = w_div_zero ? S_DONE : S_CALC;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_CALC: begin
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy_out      = (r_state == S_CALC);
        done_out      = (r_state == S_DONE);
        dbg_state_out = r_state;
    end

    // BITS_PER_CYCLE restoring steps; r_quo shifts dividend bits out and quotient bits in.
    always_comb begin
        w_part = r_part;
        w_quo  = r_quo;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            w_part = {w_part[WIDTH-1:0], w_quo[WIDTH-1]};
            w_quo  = {w_quo[WIDTH-2:0], 1'b0};
            if (w_part >= {1'b0, r_div}) begin
                w_part   = w_part - {1'b0, r_div};
                w_quo[0] = 1'b1;
            end
        end
    end

    assign w_q_fin = r_neg_q ? (~w_quo + 1'b1) : w_quo;
    assign w_r_fin = r_neg_r ? (~w_part[WIDTH-1:0] + 1'b1) : w_part[WIDTH-1:0];

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_part  <= '0;
            r_quo   <= '0;
            r_div   <= '0;
            r_cnt   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_dbz   <= 1'b0;
        end else if (w_accept) begin
            r_part  <= '0;
            r_quo   <= w_mag_a;
            r_div   <= w_mag_b;
            r_cnt   <= '0;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            if (w_div_zero) begin
                r_quot <= '1;
                r_rem  <= dividend_in;
                r_dbz  <= 1'b1;
            end else begin
                r_dbz  <= 1'b0;
            end
        end else if (r_state == S_CALC) begin
            r_part <= w_part;
            r_quo  <= w_quo;
            r_cnt  <= r_cnt + 1'b1;
            if (w_last) begin
                r_quot <= w_q_fin;
                r_rem  <= w_r_fin;
            end
        end
    end

    assign quotient_out    = r_quot;
    assign remainder_out   = r_rem;
    assign div_by_zero_out = r_dbz;

endmodule
